// File: rtl/multiplicator_arbiter.sv
// Round-robin arbiter that shares one external multiplier between N_REQ requesters.
// One operation at a time: grant, start pulse, wait for done (or time out), then respond.
module multiplicator_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                   clock,
    input  logic                   reset_in,
    input  logic [N_REQ-1:0]       req_in,
    input  logic [N_REQ*WIDTH-1:0] multiplicand_in,
    input  logic [N_REQ*WIDTH-1:0] multiplier_in,
    output logic [N_REQ-1:0]       grant_out,
    output logic [N_REQ-1:0]       done_out,
    output logic [WIDTH-1:0]       product_out,
    output logic                   overflow_out,
    output logic                   timeout_out,
    output logic [WIDTH-1:0]       mul_multiplicand_out,
    output logic [WIDTH-1:0]       mul_multiplier_out,
    output logic                   mul_start_out,
    output logic                   mul_reset_out,
    input  logic [WIDTH-1:0]       mul_product_in,
    input  logic                   mul_overflow_in,
    input  logic                   mul_done_in
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StRespond} state_e;

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [WIDTH-1:0]   product_q, product_d;
    logic               overflow_q, overflow_d;
    logic               timeout_q, timeout_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [WIDTH-1:0]   mul_b_q, mul_b_d;
    logic               mul_start_q, mul_start_d;
    logic               mul_reset_q, mul_reset_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   res_prod_q, res_prod_d;
    logic               res_ovf_q, res_ovf_d;
    logic               res_to_q, res_to_d;

    logic               found_hi, found_lo;
    logic [IDX_W-1:0]   idx_hi, idx_lo, arb_idx;
    logic [WIDTH-1:0]   sel_a, sel_b;

    // Round-robin pick: lowest requester above last_grant, else wrap to the lowest overall.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (req_in[i]) begin
                if (i > int'(last_q)) begin
                    if (!found_hi) begin
                        found_hi = 1'b1;
                        idx_hi   = IDX_W'(i);
                    end
                end else if (!found_lo) begin
                    found_lo = 1'b1;
                    idx_lo   = IDX_W'(i);
                end
            end
        end
        arb_idx = found_hi ? idx_hi : idx_lo;
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (arb_idx == IDX_W'(i)) begin
                sel_a = multiplicand_in[i*WIDTH +: WIDTH];
                sel_b = multiplier_in[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        last_d      = last_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        res_prod_d  = res_prod_q;
        res_ovf_d   = res_ovf_q;
        res_to_d    = res_to_q;
        // Pulses and result outputs are only ever high for a single cycle.
        done_d      = '0;
        product_d   = '0;
        overflow_d  = 1'b0;
        timeout_d   = 1'b0;
        mul_start_d = 1'b0;
        mul_reset_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (|req_in) begin
                    grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << arb_idx;
                    owner_d = arb_idx;
                    mul_a_d = sel_a;
                    mul_b_d = sel_b;
                    state_d = StStart;
                end
            end
            StStart: begin
                mul_start_d = 1'b1;
                cnt_d       = '0;
                state_d     = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                // The first WAIT cycle may still see a done left over from the previous job.
                if (cnt_q != '0 && mul_done_in) begin
                    res_prod_d = mul_product_in;
                    res_ovf_d  = mul_overflow_in;
                    res_to_d   = 1'b0;
                    state_d    = StRespond;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    res_prod_d  = '0;
                    res_ovf_d   = 1'b0;
                    res_to_d    = 1'b1;
                    mul_reset_d = 1'b1;
                    state_d     = StRespond;
                end
            end
            StRespond: begin
                done_d     = grant_q;
                product_d  = res_prod_q;
                overflow_d = res_ovf_q;
                timeout_d  = res_to_q;
                last_d     = owner_q;
                grant_d    = '0;
                mul_a_d    = '0;
                mul_b_d    = '0;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            done_q      <= '0;
            product_q   <= '0;
            overflow_q  <= 1'b0;
            timeout_q   <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_start_q <= 1'b0;
            mul_reset_q <= 1'b0;
            last_q      <= IDX_W'(N_REQ - 1);
            owner_q     <= '0;
            cnt_q       <= '0;
            res_prod_q  <= '0;
            res_ovf_q   <= 1'b0;
            res_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            product_q   <= product_d;
            overflow_q  <= overflow_d;
            timeout_q   <= timeout_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_start_q <= mul_start_d;
            mul_reset_q <= mul_reset_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            res_prod_q  <= res_prod_d;
            res_ovf_q   <= res_ovf_d;
            res_to_q    <= res_to_d;
        end
    end

    assign grant_out            = grant_q;
    assign done_out             = done_q;
    assign product_out          = product_q;
    assign overflow_out         = overflow_q;
    assign timeout_out          = timeout_q;
    assign mul_multiplicand_out = mul_a_q;
    assign mul_multiplier_out   = mul_b_q;
    assign mul_start_out        = mul_start_q;
    assign mul_reset_out        = mul_reset_q;

endmodule
